// File: rtl/bpred_table_if.sv
// bpred_table_if: lookup, prediction and training signals between fetch/RS and the direction table
interface bpred_table_if;
    logic        lk_valid;
    logic [31:0] lk_pc;
    logic        lk_ready;
    logic        pred_valid;
    logic        pred_taken;
    logic        tr_valid;
    logic [31:0] tr_pc;
    logic        tr_taken;
    logic        tr_ready;
    modport master (
        output lk_valid, lk_pc, tr_valid, tr_pc, tr_taken,
        input  lk_ready, pred_valid, pred_taken, tr_ready
    );
    modport slave (
        input  lk_valid, lk_pc, tr_valid, tr_pc, tr_taken,
        output lk_ready, pred_valid, pred_taken, tr_ready
    );
endinterface

// File: rtl/bpred_table_ctrl.sv
// bpred_table_ctrl: 2-bit counter branch table with init walk, lookup/training arbitration and training FIFO
module bpred_table_ctrl #(
    parameter int         IDX_W    = 6,
    parameter int         TQ_DEPTH = 4,
    parameter logic [1:0] INIT_CTR = 2'b01
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         rdy,
    bpred_table_if.slave bus,
    output logic         init_busy
);
    localparam int QW = $clog2(TQ_DEPTH);
    typedef enum logic {INIT, RUN} state_t;
    state_t state, state_nx;
    logic [IDX_W-1:0] ptr, lk_idx, tr_idx, upd_idx;
    logic [1:0] tbl [2**IDX_W];
    logic [IDX_W-1:0] q_idx [TQ_DEPTH];
    logic q_tk [TQ_DEPTH];
    logic [QW-1:0] head, tail;
    logic [QW:0] count;
    logic run, full, lk_acc, push, pop;
    logic [1:0] cur, upd;
    logic unused;
    assign lk_idx = bus.lk_pc[IDX_W+1:2];
    assign tr_idx = bus.tr_pc[IDX_W+1:2];
    assign unused = ^{bus.lk_pc[31:IDX_W+2], bus.lk_pc[1:0], bus.tr_pc[31:IDX_W+2], bus.tr_pc[1:0]};
    // State register; reset restarts the walk regardless of rdy
    always_ff @(posedge clk)
        state <= rst ? INIT : state_nx;
    // Leave INIT on the cycle that writes the last entry
    always_comb
        state_nx = (state == INIT && rdy && ptr == '1) ? RUN : state;
    // Handshakes and arbitration: full queue beats lookup, lookup beats draining
    always_comb begin
        run          = state == RUN && rdy && !rst;
        full         = count == (QW+1)'(TQ_DEPTH);
        bus.lk_ready = run && !full;
        bus.tr_ready = run && !full;
        init_busy    = rst || state == INIT;
        lk_acc       = bus.lk_valid && bus.lk_ready;
        push         = bus.tr_valid && bus.tr_ready;
        pop          = run && count != '0 && !lk_acc;
        upd_idx      = q_idx[head];
        cur          = tbl[upd_idx];
        upd          = q_tk[head] ? (cur == 2'd3 ? cur : cur + 2'd1) : (cur == 2'd0 ? cur : cur - 2'd1);
    end
    // Walk pointer and queue bookkeeping; frozen while rdy is low
    always_ff @(posedge clk) begin
        if (rst) begin
            ptr   <= '0;
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else if (rdy) begin
            if (state == INIT) ptr <= ptr + 1'b1;
            head  <= head + QW'(pop);
            tail  <= tail + QW'(push);
            count <= count + (QW+1)'(push) - (QW+1)'(pop);
        end
    end
    // Queue payload storage
    always_ff @(posedge clk)
        if (push) begin
            q_idx[tail] <= tr_idx;
            q_tk[tail]  <= bus.tr_taken;
        end
    // Single table write port: init walk or saturating update from queue head
    always_ff @(posedge clk)
        if (!rst && rdy && state == INIT) tbl[ptr] <= INIT_CTR;
        else if (pop) tbl[upd_idx] <= upd;
    // One-cycle prediction result; direction holds between pulses
    always_ff @(posedge clk)
        if (rst) begin
            bus.pred_valid <= 1'b0;
            bus.pred_taken <= 1'b0;
        end else begin
            bus.pred_valid <= lk_acc;
            if (lk_acc) bus.pred_taken <= tbl[lk_idx][1];
        end
endmodule

// File: tb/tb_bpred_table_ctrl.sv
// tb_bpred_table_ctrl: directed checks of init walk, saturation, arbitration, FIFO wrap, freeze and reset
module tb_bpred_table_ctrl;
    logic clk, rst, rdy, init_busy;
    int checks = 0;
    int errors = 0;
    bpred_table_if bus();
    bpred_table_ctrl dut (.clk(clk), .rst(rst), .rdy(rdy), .bus(bus), .init_busy(init_busy));
    initial clk = 1'b0;
    always #5 clk = ~clk;
    task automatic tick;
        @(posedge clk);
        #1;
    endtask
    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask
    task automatic train(input logic [31:0] pc, input logic tk);
        int n = 0;
        bus.tr_valid = 1'b1;
        bus.tr_pc    = pc;
        bus.tr_taken = tk;
        #1;
        while (!bus.tr_ready && n < 100) begin
            tick;
            n++;
        end
        chk("tr_wait", 32'(n < 100), 1);
        tick;
        bus.tr_valid = 1'b0;
    endtask
    task automatic lookup(input string tag, input logic [31:0] pc, input logic exp);
        int n = 0;
        bus.lk_valid = 1'b1;
        bus.lk_pc    = pc;
        #1;
        while (!bus.lk_ready && n < 100) begin
            tick;
            n++;
        end
        chk({tag, "_wait"}, 32'(n < 100), 1);
        tick;
        bus.lk_valid = 1'b0;
        chk({tag, "_pv"}, bus.pred_valid, 1);
        chk(tag, bus.pred_taken, exp);
        tick;
        chk({tag, "_pv_drop"}, bus.pred_valid, 0);
    endtask
    task automatic walk(input string tag);
        int n = 0;
        while (init_busy && n < 200) begin
            tick;
            n++;
        end
        chk(tag, n, 64);
    endtask
    initial begin
        rst = 1'b1; rdy = 1'b1;
        bus.lk_valid = 1'b0; bus.lk_pc = '0;
        bus.tr_valid = 1'b0; bus.tr_pc = '0; bus.tr_taken = 1'b0;
        tick; tick;
        chk("rst_busy", init_busy, 1);
        chk("rst_lk_ready", bus.lk_ready, 0);
        chk("rst_tr_ready", bus.tr_ready, 0);
        chk("rst_pv", bus.pred_valid, 0);
        chk("rst_pt", bus.pred_taken, 0);
        chk("rst_count", dut.count, 0);
        rst = 1'b0;
        walk("init_cycles");
        chk("run_lk_ready", bus.lk_ready, 1);
        chk("run_tr_ready", bus.tr_ready, 1);
        lookup("init_pred", 32'h100, 1'b0);
        // saturate up: 01 -> 2 -> 3 -> 3
        repeat (3) train(32'h40, 1'b1);
        repeat (4) tick;
        lookup("up3", 32'h40, 1'b1);
        train(32'h40, 1'b1);
        train(32'h40, 1'b0);
        repeat (4) tick;
        lookup("up_then_down", 32'h40, 1'b1);
        train(32'h40, 1'b0);
        repeat (4) tick;
        lookup("down_to_1", 32'h40, 1'b0);
        // saturate down: 01 -> 0 -> 0 -> 0
        repeat (3) train(32'h44, 1'b0);
        repeat (4) tick;
        lookup("dn3", 32'h44, 1'b0);
        train(32'h44, 1'b1);
        repeat (4) tick;
        lookup("dn_then_up", 32'h44, 1'b0);
        train(32'h44, 1'b1);
        repeat (4) tick;
        lookup("dn_up2", 32'h44, 1'b1);
        // arbitration: lookups every cycle, queue fills with T,T,N,N for 0x80
        bus.lk_valid = 1'b1; bus.lk_pc = 32'h300;
        train(32'h80, 1'b1);
        train(32'h80, 1'b1);
        train(32'h80, 1'b0);
        train(32'h80, 1'b0);
        chk("full_count", dut.count, 4);
        chk("full_lk_ready", bus.lk_ready, 0);
        chk("full_tr_ready", bus.tr_ready, 0);
        chk("full_pv", bus.pred_valid, 1);
        tick;
        chk("pop_count", dut.count, 3);
        chk("pop_pv", bus.pred_valid, 0);
        chk("pop_lk_ready", bus.lk_ready, 1);
        tick;
        chk("resume_pv", bus.pred_valid, 1);
        chk("resume_count", dut.count, 3);
        bus.lk_valid = 1'b0;
        repeat (6) tick;
        chk("drain_count", dut.count, 0);
        lookup("arb_order", 32'h80, 1'b0);
        // simultaneous push/pop at count 2 across 10 entries
        bus.lk_valid = 1'b1; bus.lk_pc = 32'h300;
        train(32'hC0, 1'b1);
        train(32'hC0, 1'b1);
        chk("pp_pre_count", dut.count, 2);
        bus.lk_valid = 1'b0;
        train(32'hC4, 1'b0); chk("pp_count0", dut.count, 2);
        train(32'hC4, 1'b0); chk("pp_count1", dut.count, 2);
        train(32'hC4, 1'b0); chk("pp_count2", dut.count, 2);
        train(32'hC0, 1'b0); chk("pp_count3", dut.count, 2);
        train(32'hC0, 1'b0); chk("pp_count4", dut.count, 2);
        train(32'hC0, 1'b0); chk("pp_count5", dut.count, 2);
        train(32'hC4, 1'b1); chk("pp_count6", dut.count, 2);
        train(32'hC4, 1'b1); chk("pp_count7", dut.count, 2);
        repeat (4) tick;
        lookup("pp_a", 32'hC0, 1'b0);
        lookup("pp_b", 32'hC4, 1'b1);
        // rdy freeze with two queued updates and a pending push request
        bus.lk_valid = 1'b1; bus.lk_pc = 32'h300;
        train(32'hE0, 1'b1);
        train(32'hE0, 1'b1);
        rdy = 1'b0;
        bus.tr_valid = 1'b1; bus.tr_pc = 32'hE0; bus.tr_taken = 1'b0;
        #1;
        chk("frz_lk_ready", bus.lk_ready, 0);
        chk("frz_tr_ready", bus.tr_ready, 0);
        chk("frz_last_pv", bus.pred_valid, 1);
        chk("frz_count0", dut.count, 2);
        for (int i = 0; i < 5; i++) begin
            tick;
            chk("frz_pv", bus.pred_valid, 0);
            chk("frz_count", dut.count, 2);
            chk("frz_lk", bus.lk_ready, 0);
        end
        rdy = 1'b1; bus.tr_valid = 1'b0; bus.lk_valid = 1'b0;
        repeat (4) tick;
        lookup("frz_after", 32'hE0, 1'b1);
        // reset mid-run with queued updates, then mid-walk at ptr 30
        bus.lk_valid = 1'b1; bus.lk_pc = 32'h300;
        train(32'hE0, 1'b0);
        train(32'hE0, 1'b0);
        chk("mr_count", dut.count, 2);
        rst = 1'b1; bus.lk_valid = 1'b0;
        #1;
        chk("mr_lk_ready", bus.lk_ready, 0);
        chk("mr_tr_ready", bus.tr_ready, 0);
        chk("mr_busy", init_busy, 1);
        tick;
        chk("mr_flush", dut.count, 0);
        chk("mr_ptr", dut.ptr, 0);
        rst = 1'b0;
        repeat (30) tick;
        chk("mw_ptr30", dut.ptr, 30);
        chk("mw_busy", init_busy, 1);
        rst = 1'b1;
        tick;
        chk("mw_ptr0", dut.ptr, 0);
        rst = 1'b0;
        walk("rewalk_cycles");
        repeat (4) tick;
        chk("rewalk_count", dut.count, 0);
        lookup("rewalk_pred", 32'hE0, 1'b0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
